uart_mmio_fifo: RTL and testbench

- Memory-mapped UART front end with parametrised TX and RX byte FIFOs, status/count register, sticky error flags and 32-bit traffic counters.
- Sits between the MIPS memory stage (ALU address, store data, load/store strobes, stall) and the UART transmitter/receiver valid/ready ports.
- CPU software no longer blocks per byte: it can queue up to DEPTH bytes each way.
- Register decode is an exact match on BASE_ADDR plus fixed offsets.

---
 rtl/uart_mmio_fifo.sv | 88 ++++++++
 tb/tb_uart_mmio_fifo.sv | 125 ++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped UART front end with TX/RX byte FIFOs, status, sticky flags and traffic counters
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  input  logic        stall,
  output logic [31:0] rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] A_TXNF = BASE_ADDR;
  localparam logic [31:0] A_RXNE = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_TXD  = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_RXD  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_STAT = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_TXB  = BASE_ADDR + 32'h14;
  localparam logic [31:0] A_RXB  = BASE_ADDR + 32'h18;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_head, tx_tail, rx_head, rx_tail;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_overflow, rx_underflow;
  logic [31:0] tx_bytes, rx_bytes;
  logic tx_full, rx_empty, tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push, clr, rd_en;
  assign tx_full     = tx_count == CW'(DEPTH);
  assign rx_empty    = rx_count == '0;
  assign tx_push_req = !stall && we && addr == A_TXD;
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = uart_din_ready && uart_din_valid;
  assign rx_pop_req  = !stall && re && addr == A_RXD;
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_push     = uart_dout_valid && uart_dout_ready;
  assign clr         = !stall && we && addr == A_STAT;
  assign rd_en       = re && !stall;
  assign uart_din_valid  = tx_count != '0;
  assign uart_din        = uart_din_valid ? tx_mem[tx_head] : 8'd0;
  assign uart_dout_ready = rx_count != CW'(DEPTH);
  always_comb
    rdata = !rd_en           ? 32'd0 :
            addr == A_TXNF   ? {31'd0, !tx_full} :
            addr == A_RXNE   ? {31'd0, !rx_empty} :
            addr == A_RXD    ? (rx_empty ? 32'd0 : {24'd0, rx_mem[rx_head]}) :
            addr == A_STAT   ? {6'd0, rx_underflow, tx_overflow, 8'(rx_count), 8'd0, 8'(tx_count)} :
            addr == A_TXB    ? tx_bytes :
            addr == A_RXB    ? rx_bytes : 32'd0;
  // FIFO storage needs no reset: emptiness is tracked by the counts alone
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_tail] <= wdata;
    if (rx_push) rx_mem[rx_tail] <= uart_dout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_head <= '0;
      tx_tail <= '0;
      rx_head <= '0;
      rx_tail <= '0;
      tx_count <= '0;
      rx_count <= '0;
      tx_overflow <= 1'b0;
      rx_underflow <= 1'b0;
      tx_bytes <= '0;
      rx_bytes <= '0;
    end else begin
      if (tx_push) tx_tail <= tx_tail + AW'(1);
      if (tx_pop) tx_head <= tx_head + AW'(1);
      if (rx_push) rx_tail <= rx_tail + AW'(1);
      if (rx_pop) rx_head <= rx_head + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      tx_overflow <= clr ? 1'b0 : tx_overflow | (tx_push_req && tx_full);
      rx_underflow <= clr ? 1'b0 : rx_underflow | (rx_pop_req && rx_empty);
      tx_bytes <= clr ? 32'd0 : tx_bytes + 32'(tx_pop);
      rx_bytes <= clr ? 32'd0 : rx_bytes + 32'(rx_push);
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed self-checking bench for uart_mmio_fifo
module tb_uart_mmio_fifo;
  localparam logic [31:0] B = 32'h80000000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0;
  logic [7:0] wdata = '0, uart_dout = '0;
  logic we = 1'b0, re = 1'b0, stall = 1'b0, uart_din_ready = 1'b0, uart_dout_valid = 1'b0;
  logic [31:0] rdata;
  logic [7:0] uart_din;
  logic uart_din_valid, uart_dout_ready;
  int errors = 0, checks = 0;
  uart_mmio_fifo #(.BASE_ADDR(B), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re), .stall(stall),
    .rdata(rdata), .uart_din(uart_din), .uart_din_valid(uart_din_valid),
    .uart_din_ready(uart_din_ready), .uart_dout(uart_dout),
    .uart_dout_valid(uart_dout_valid), .uart_dout_ready(uart_dout_ready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
    addr = B + off;
    re = 1'b1;
    #1;
    chk(tag, rdata, exp);
    tick();
    re = 1'b0;
  endtask
  task automatic wr(input logic [31:0] off, input logic [7:0] d);
    addr = B + off;
    wdata = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_din_valid", 32'(uart_din_valid), 32'd0);
    chk("rst_dout_ready", 32'(uart_dout_ready), 32'd1);
    chk("rst_din", 32'(uart_din), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(32'h00, 32'd1, "txnf_init");
    rd(32'h04, 32'd0, "rxne_init");
    rd(32'h10, 32'd0, "stat_init");
    rd(32'h20, 32'd0, "unmapped");
    addr = B;
    re = 1'b0;
    #1;
    chk("re_low_rdata", rdata, 32'd0);
    wr(32'h08, 8'h41);
    chk("push_latency", 32'(uart_din), 32'h41);
    wr(32'h08, 8'h42);
    wr(32'h08, 8'h43);
    rd(32'h10, 32'h0000_0003, "stat_tx3");
    uart_din_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("tx_drain3", 32'(uart_din), 32'h41 + i);
      tick();
    end
    uart_din_ready = 1'b0;
    chk("tx_empty_valid", 32'(uart_din_valid), 32'd0);
    rd(32'h14, 32'd3, "tx_bytes3");
    for (int i = 0; i < 9; i++) wr(32'h08, 8'h50 + 8'(i));
    rd(32'h10, 32'h0100_0008, "stat_ovf");
    rd(32'h00, 32'd0, "txnf_full");
    wr(32'h10, 8'h00);
    rd(32'h10, 32'h0000_0008, "stat_clr");
    rd(32'h14, 32'd0, "tx_bytes_clr");
    rd(32'h18, 32'd0, "rx_bytes_clr");
    uart_din_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tx_drain8", 32'(uart_din), 32'h50 + i);
      tick();
    end
    uart_din_ready = 1'b0;
    chk("tx_drained", 32'(uart_din_valid), 32'd0);
    rd(32'h14, 32'd8, "tx_bytes8");
    uart_dout_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      uart_dout = 8'h10 + 8'(i);
      tick();
    end
    uart_dout_valid = 1'b0;
    chk("rx_full_ready", 32'(uart_dout_ready), 32'd0);
    rd(32'h10, 32'h0008_0000, "stat_rx8");
    rd(32'h18, 32'd8, "rx_bytes8");
    rd(32'h04, 32'd1, "rxne_full");
    stall = 1'b1;
    rd(32'h0C, 32'd0, "stall_rdata");
    stall = 1'b0;
    rd(32'h10, 32'h0008_0000, "stall_no_pop");
    for (int i = 0; i < 8; i++) rd(32'h0C, 32'h10 + i, "rx_pop");
    chk("rx_ready_again", 32'(uart_dout_ready), 32'd1);
    rd(32'h0C, 32'd0, "rx_underflow_rd");
    rd(32'h10, 32'h0200_0000, "stat_unf");
    for (int i = 0; i < 5; i++) wr(32'h08, 8'hA0 + 8'(i));
    chk("mid_valid", 32'(uart_din_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(uart_din_valid), 32'd0);
    chk("async_rst_din", 32'(uart_din), 32'd0);
    tick();
    rst = 1'b0;
    rd(32'h10, 32'd0, "post_rst_stat");
    rd(32'h14, 32'd0, "post_rst_txb");
    rd(32'h18, 32'd0, "post_rst_rxb");
    rd(32'h00, 32'd1, "post_rst_txnf");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
